// File: rtl/uart_byte_receiver_if.sv
// CPU-side byte handshake of the UART receiver: one held byte, ready/ack, error flags.
// The receiver drives through master; the CPU peripheral logic connects through slave.
interface uart_byte_receiver_if;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       rx_busy;

    modport master (
        input  rx_ack,
        output rx_data, rx_ready, frame_err, overrun, rx_busy
    );

    modport slave (
        output rx_ack,
        input  rx_data, rx_ready, frame_err, overrun, rx_busy
    );
endinterface

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x oversampling with 3-sample majority vote,
// one-byte holding register with ready/ack handshake, frame-error pulse and sticky overrun.
module uart_byte_receiver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                        SystemClk,
    input  logic                        reset,
    input  logic                        RX,
    uart_byte_receiver_if.master        cpu
);

    localparam int DIV_RAW = (CLK_FREQ + BAUD * (OVERSAMPLE / 2)) / (BAUD * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int CNT_W   = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t     state;
    state_t     next_state;

    logic       sync_a;
    logic       sync_b;
    logic       sync_prev;
    logic [CNT_W-1:0] tick_cnt;
    logic [3:0] sub;
    logic [2:0] bit_idx;
    logic       sample_a;
    logic       sample_b;
    logic [7:0] shift_reg;
    logic       deliver_pend;

    logic [7:0] data_q;
    logic       ready_q;
    logic       frame_err_q;
    logic       overrun_q;

    logic       tick;
    logic       vote;
    logic       at_mid;
    logic       at_end;
    logic       load_bit;
    logic       deliver;
    logic       frame_bad;

    assign tick   = (state != S_IDLE) && (tick_cnt == CNT_W'(DIV - 1));
    assign at_mid = tick && (sub == 4'd9);
    assign at_end = tick && (sub == 4'd15);
    // Third sample is the live synchronised line on the s=9 tick itself.
    assign vote   = (sample_a & sample_b) | (sample_a & sync_b) | (sample_b & sync_b);

    always_ff @(posedge SystemClk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        next_state = state;
        load_bit   = 1'b0;
        deliver    = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            S_IDLE: begin
                if (sync_prev && !sync_b) next_state = S_START;
            end
            S_START: begin
                if (at_mid && vote)  next_state = S_IDLE;
                else if (at_end)     next_state = S_DATA;
            end
            S_DATA: begin
                load_bit = at_mid;
                if (at_end && (bit_idx == 3'd7)) next_state = S_STOP;
            end
            S_STOP: begin
                if (at_mid) begin
                    if (vote) begin
                        deliver    = 1'b1;
                        next_state = S_IDLE;
                    end else begin
                        frame_bad  = 1'b1;
                        next_state = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                if (sync_b) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge SystemClk or negedge reset) begin
        if (!reset) begin
            sync_a       <= 1'b1;
            sync_b       <= 1'b1;
            sync_prev    <= 1'b1;
            tick_cnt     <= '0;
            sub          <= '0;
            bit_idx      <= '0;
            sample_a     <= 1'b0;
            sample_b     <= 1'b0;
            shift_reg    <= '0;
            deliver_pend <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            sync_a       <= RX;
            sync_b       <= sync_a;
            sync_prev    <= sync_b;
            deliver_pend <= deliver;
            frame_err_q  <= frame_bad;

            // Held at zero while idle so a start edge always begins a fresh bit period.
            if (state == S_IDLE || tick) tick_cnt <= '0;
            else                         tick_cnt <= tick_cnt + 1'b1;

            if (state == S_IDLE) sub <= '0;
            else if (tick)       sub <= sub + 1'b1;

            if (state != S_DATA) bit_idx <= '0;
            else if (at_end)     bit_idx <= bit_idx + 1'b1;

            if (tick && (sub == 4'd7)) sample_a <= sync_b;
            if (tick && (sub == 4'd8)) sample_b <= sync_b;

            if (load_bit) shift_reg[bit_idx] <= vote;
        end
    end

    always_ff @(posedge SystemClk or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (deliver_pend) begin
            // An ack in the deliver cycle frees the holding register for the new byte.
            if (!ready_q || cpu.rx_ack) begin
                data_q    <= shift_reg;
                ready_q   <= 1'b1;
                overrun_q <= 1'b0;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (cpu.rx_ack && ready_q) begin
            ready_q   <= 1'b0;
            overrun_q <= 1'b0;
        end
    end

    assign cpu.rx_data   = data_q;
    assign cpu.rx_ready  = ready_q;
    assign cpu.frame_err = frame_err_q;
    assign cpu.overrun   = overrun_q;
    assign cpu.rx_busy   = (state != S_IDLE);

endmodule
